// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: register address width, the decode control
// bundle carried down the pipe, and its all-zero NOP value.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned REG_ADDR_W   = 5;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic       jump;
        logic [3:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: a load sitting in EX whose non-zero destination
// register is actually read by the instruction in decode.
module hazard_detect
    import riscv_pkg::*;
(
    input  logic                  ex_valid,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  id_valid,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    output logic                  load_use
);

    logic rs1_match;
    logic rs2_match;

    always_comb begin
        rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);
        load_use  = ex_valid && ex_memread && (ex_rd != '0) && id_valid
                    && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, memory-stall hold,
// branch flush and a saturating count of inserted load-use bubbles.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  ctrl_t                 id_ctrl,
    input  logic                  ex_flush,
    input  logic                  mem_stall,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [XLEN-1:0]       ex_rs1_data,
    output logic [XLEN-1:0]       ex_rs2_data,
    output ctrl_t                 ex_ctrl,
    output logic                  hazard_stall,
    output logic [15:0]           lu_bubble_cnt
);

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        ctrl_t                 ctrl;
    } ex_reg_t;

    ex_reg_t     ex_d;
    ex_reg_t     ex_q;
    ex_reg_t     id_slot;
    logic [15:0] cnt_d;
    logic [15:0] cnt_q;
    logic        load_use;

    hazard_detect u_hazard_detect (
        .ex_valid    (ex_q.valid),
        .ex_memread  (ex_q.ctrl.memread),
        .ex_rd       (ex_q.rd),
        .id_valid    (id_valid),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .load_use    (load_use)
    );

    always_comb begin
        // An invalid decode slot enters EX as an all-zero bubble.
        id_slot = '0;
        if (id_valid) begin
            id_slot.valid    = 1'b1;
            id_slot.pc       = id_pc;
            id_slot.imm      = id_imm;
            id_slot.rs1      = id_rs1;
            id_slot.rs2      = id_rs2;
            id_slot.rd       = id_rd;
            id_slot.rs1_data = id_rs1_data;
            id_slot.rs2_data = id_rs2_data;
            id_slot.ctrl     = id_ctrl;
        end

        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (!mem_stall) begin
            if (ex_flush) begin
                ex_d = '0;
            end else if (load_use) begin
                ex_d = '0;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end else begin
                ex_d = id_slot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        hazard_stall  = load_use && !ex_flush;
        ex_valid      = ex_q.valid;
        ex_pc         = ex_q.pc;
        ex_imm        = ex_q.imm;
        ex_rs1        = ex_q.rs1;
        ex_rs2        = ex_q.rs2;
        ex_rd         = ex_q.rd;
        ex_rs1_data   = ex_q.rs1_data;
        ex_rs2_data   = ex_q.rs2_data;
        ex_ctrl       = ex_q.ctrl;
        lu_bubble_cnt = cnt_q;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width of PC, operand and immediate fields.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 id_valid  input  1  decode slot holds a real instruction.
REQ-005 id_pc, id_imm  input  XLEN each  decode PC and sign-extended immediate.
REQ-006 id_rs1, id_rs2, id_rd  input  5 each  decode register addresses.
REQ-007 id_uses_rs1, id_uses_rs2  input  1 each  instruction actually reads rs1/rs2 (0 for LUI/AUIPC/JAL etc.).
REQ-008 id_rs1_data, id_rs2_data  input  XLEN each  register-file read data.
REQ-009 id_ctrl  input  ctrl_t  decode control bundle: regwrite, memread, memwrite, memtoreg, alusrc, branch, jump, aluop[3:0].
REQ-010 ex_flush  input  1  taken branch/jump resolved in EX; discard the decode slot.
REQ-011 mem_stall  input  1  data memory busy; freeze this register.
REQ-012 ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_ctrl  output  widths as inputs  registered EX-stage copy; ex_rs1/ex_rs2/ex_rd feed the forwarding unit.
REQ-013 hazard_stall  output  1  combinational: hold PC and IF/ID register this cycle.
REQ-014 lu_bubble_cnt  output  16  saturating count of load-use bubbles inserted.

Function
REQ-015 Load-use hazard = ex_valid & ex_ctrl.memread & (ex_rd!=0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-016 hazard_stall SHALL equal load-use hazard & !ex_flush; flush overrides stall.
REQ-017 Per-edge priority SHALL be: rst > mem_stall (hold all registers) > ex_flush (bubble) > load-use hazard (bubble) > load from decode.
REQ-018 Bubble SHALL set ex_valid=0, ex_ctrl=0, ex_rs1=ex_rs2=ex_rd=0, all data fields 0, so no forward or write can match.
REQ-019 Load SHALL copy every id_* field; if id_valid=0 the stage SHALL load a bubble instead.
REQ-020 Latency: decode fields appear on ex_* exactly one cycle after an unstalled, unflushed edge.
REQ-021 mem_stall with load-use: hazard_stall still asserts; register holds; no bubble counted until mem_stall deasserts.
REQ-022 A load-use bubble SHALL last exactly one cycle: next cycle the load has left EX, hazard clears, the held instruction loads.
REQ-023 lu_bubble_cnt SHALL increment only on edges that insert a load-use bubble (not flush bubbles, not held cycles), saturating at 16'hFFFF.
REQ-024 x0 as rd never triggers a hazard; rs fields with uses_rs*=0 never trigger one.

Reset
REQ-025 On rst=1 at a rising edge all ex_* outputs and lu_bubble_cnt SHALL be 0; rst overrides mem_stall and ex_flush.
REQ-026 Reset mid-stall SHALL clear the stage; hazard_stall falls to 0 because ex_valid=0.

Structure
REQ-027 Package riscv_pkg SHALL hold XLEN default, REG_ADDR_W=5, ctrl_t packed struct, and CTRL_NOP constant (all zero).
REQ-028 Load-use detection SHALL be a combinational sub-module hazard_detect; register and counter live in id_ex_stage.

Verification
REQ-029 LW x5 in EX (memread=1, rd=5), decode ADD rs1=5 uses_rs1=1 -> hazard_stall=1, next edge ex_valid=0, ex_rd=0, lu_bubble_cnt=1; following edge ADD loads.
REQ-030 Same but decode LUI rd=5 (uses_rs1=0, id_rs1 field=5) -> hazard_stall=0, LUI loads next edge, counter unchanged.
REQ-031 Load-use plus ex_flush=1 same cycle -> hazard_stall=0, bubble loaded, counter unchanged.
REQ-032 mem_stall=1 for 3 cycles with new id_* values each cycle -> ex_* unchanged for 3 edges, then loads current decode values.
REQ-033 LW rd=0 followed by ADD rs1=0 -> no stall; rst=1 mid-bubble -> all outputs 0 next edge.
REQ-034 Force 65536 load-use bubbles -> lu_bubble_cnt holds 16'hFFFF.
